position_ram_host_bridge: RTL

//   Host-side initiator for the test-pattern position RAM (2-cycle-latency lookahead memory).

---
 rtl/position_ram_pkg.sv | 22 ++
 rtl/position_ram_host_bridge_if.sv | 23 ++
 rtl/position_ram_rd_pipe.sv | 53 +++++
 rtl/position_ram_host_bridge.sv | 137 +++++++++++++
 4 files changed

// File: rtl/position_ram_pkg.sv
// Shared types and register map for the position RAM host bridge.
package position_ram_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        FILL = 2'd2
    } state_t;

    // Source of the data returned with a read response.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_REG  = 2'd2
    } rd_sel_t;

    localparam int REG_STATUS       = 0;
    localparam int REG_FILL         = 1;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_BUSY_BIT  = 1;

endpackage

// File: rtl/position_ram_host_bridge_if.sv
// Avalon-MM slave bus between the control CPU (master) and the bridge (slave).
interface position_ram_host_bridge_if #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 16
);
    logic [ADDR_W:0]   av_address;
    logic              av_write;
    logic [DATA_W-1:0] av_writedata;
    logic              av_read;
    logic              av_waitrequest;
    logic [DATA_W-1:0] av_readdata;
    logic              av_readdatavalid;

    modport master (
        output av_address, av_write, av_writedata, av_read,
        input  av_waitrequest, av_readdata, av_readdatavalid
    );

    modport slave (
        input  av_address, av_write, av_writedata, av_read,
        output av_waitrequest, av_readdata, av_readdatavalid
    );
endinterface

// File: rtl/position_ram_rd_pipe.sv
// Read response pipeline: carries valid/select/register data for LATENCY+1 cycles,
// then picks memory data, register data or zero for the host response.
module position_ram_rd_pipe
    import position_ram_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue,
    input  rd_sel_t           sel,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] mem_rd_readdata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);
    localparam int STAGES = LATENCY + 1;

    logic [STAGES-1:0] valid_r;
    rd_sel_t           sel_r  [STAGES];
    logic [DATA_W-1:0] regd_r [STAGES];

    // Shift register; only reset flushes it, stalls upstream never touch it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sel_r[i]  <= SEL_ZERO;
                regd_r[i] <= '0;
            end
        end else begin
            valid_r   <= {valid_r[STAGES-2:0], issue};
            sel_r[0]  <= issue ? sel : SEL_ZERO;
            regd_r[0] <= issue ? reg_data : '0;
            for (int i = 1; i < STAGES; i++) begin
                sel_r[i]  <= sel_r[i-1];
                regd_r[i] <= regd_r[i-1];
            end
        end
    end

    // Memory data arrives exactly when its select reaches the last stage.
    always_comb begin
        readdatavalid = valid_r[STAGES-1];
        case (sel_r[STAGES-1])
            SEL_MEM: readdata = mem_rd_readdata;
            SEL_REG: readdata = regd_r[STAGES-1];
            default: readdata = '0;
        endcase
    end

endmodule

// File: rtl/position_ram_host_bridge.sv
// Host bridge from the CPU Avalon-MM port onto the position RAM write/read ports.
// Optional bulk FILL engine is built when POSITION_RAM_FILL_EN is defined.
module position_ram_host_bridge
    import position_ram_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int ADDR_W         = 1,
    parameter int DATA_W         = 16,
    parameter int MEM_RD_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    position_ram_host_bridge_if.slave  av,
    output logic [ADDR_W-1:0]          mem_wr_address,
    output logic [DATA_W-1:0]          mem_wr_writedata,
    output logic                       mem_wr_write,
    input  logic                       mem_wr_waitrequest,
    output logic [ADDR_W-1:0]          mem_rd_address,
    input  logic [DATA_W-1:0]          mem_rd_readdata
);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] fill_cnt_r;
    logic [DATA_W-1:0] fill_val_r;
    logic [ADDR_W-1:0] rd_addr_r;

    logic              wait_s, is_reg_s, in_range_s;
    logic              wr_acc_s, rd_acc_s, mem_wr_s, fill_start_s;
    logic [ADDR_W-1:0] offs_s;
    logic [DATA_W-1:0] status_s;
    rd_sel_t           rd_sel_s;

    // Request decode and acceptance; a simultaneous read+write keeps only the write.
    always_comb begin
        is_reg_s   = av.av_address[ADDR_W];
        offs_s     = av.av_address[ADDR_W-1:0];
        in_range_s = ({1'b0, offs_s} < DEPTH_L);
        wait_s     = (state_r != IDLE) | (av.av_write & mem_wr_waitrequest);
        wr_acc_s   = av.av_write & ~wait_s;
        rd_acc_s   = av.av_read & ~av.av_write & ~wait_s;
        mem_wr_s   = wr_acc_s & ~is_reg_s & in_range_s;
`ifdef POSITION_RAM_FILL_EN
        fill_start_s = wr_acc_s & is_reg_s & (offs_s == ADDR_W'(REG_FILL));
`else
        fill_start_s = 1'b0;
`endif
        status_s = '0;
        status_s[STATUS_READY_BIT] = (state_r != INIT);
`ifdef POSITION_RAM_FILL_EN
        status_s[STATUS_BUSY_BIT] = (state_r == FILL);
`endif
        if (!is_reg_s) begin
            rd_sel_s = in_range_s ? SEL_MEM : SEL_ZERO;
        end else if (offs_s == ADDR_W'(REG_STATUS)) begin
            rd_sel_s = SEL_REG;
        end else begin
            rd_sel_s = SEL_ZERO;
        end
    end

    assign av.av_waitrequest = wait_s;
    assign mem_rd_address    = rd_addr_r;

    // Write port: fill engine owns it while filling, otherwise host writes pass straight through.
    always_comb begin
        if ((state_r == FILL) && !mem_wr_waitrequest) begin
            mem_wr_write     = 1'b1;
            mem_wr_address   = fill_cnt_r;
            mem_wr_writedata = fill_val_r;
        end else if (mem_wr_s) begin
            mem_wr_write     = 1'b1;
            mem_wr_address   = offs_s;
            mem_wr_writedata = av.av_writedata;
        end else begin
            mem_wr_write     = 1'b0;
            mem_wr_address   = '0;
            mem_wr_writedata = '0;
        end
    end

    // Control FSM; any rise of the memory busy flag (clear sweep) drops back to INIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= INIT;
            fill_cnt_r <= '0;
            fill_val_r <= '0;
            rd_addr_r  <= '0;
        end else begin
            if (rd_acc_s && !is_reg_s) begin
                rd_addr_r <= offs_s;
            end
            case (state_r)
                INIT: begin
                    if (!mem_wr_waitrequest) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (mem_wr_waitrequest) begin
                        state_r <= INIT;
                    end else if (fill_start_s) begin
                        state_r    <= FILL;
                        fill_cnt_r <= '0;
                        fill_val_r <= av.av_writedata;
                    end
                end
                FILL: begin
                    if (mem_wr_waitrequest) begin
                        state_r <= INIT;
                    end else if (fill_cnt_r == LAST_L) begin
                        state_r <= IDLE;
                    end else begin
                        fill_cnt_r <= fill_cnt_r + 1'b1;
                    end
                end
                default: state_r <= INIT;
            endcase
        end
    end

    position_ram_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (MEM_RD_LATENCY)
    ) u_rd_pipe (
        .clk             (clk),
        .reset_n         (reset_n),
        .issue           (rd_acc_s),
        .sel             (rd_sel_s),
        .reg_data        (status_s),
        .mem_rd_readdata (mem_rd_readdata),
        .readdata        (av.av_readdata),
        .readdatavalid   (av.av_readdatavalid)
    );

endmodule
